// File: rtl/ins_decode_stage.sv
// Registered MIPS decode stage with a two-entry skid buffer (main + skid).
// Optional illegal-opcode flag is enabled by defining INS_DECODE_ILLEGAL_EN.
module ins_decode_stage #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [PC_W-1:0]   p_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [1:0]        fmt,
  output logic [15:0]       immediate,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       address,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   jump_target,
  output logic [CNT_W-1:0]  decode_count
`ifdef INS_DECODE_ILLEGAL_EN
  ,
  output logic              illegal
`endif
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [1:0]        fmt;
    logic [15:0]       immediate;
    logic [DATA_W-1:0] imm_ext;
    logic [25:0]       address;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   jump_target;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    logic signed [15:0]       simm;
    logic signed [DATA_W-1:0] sx;
    logic [31:0]              lui;
    simm = imm;
    sx   = DATA_W'(simm);
    lui  = {imm, 16'h0000};
    case (op)
      6'h0C, 6'h0D, 6'h0E: ext_imm = DATA_W'(imm);
      6'h0F:               ext_imm = DATA_W'(lui);
      default:             ext_imm = sx;
    endcase
  endfunction

  // Word offset of a branch: always sign-extended, wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_off(input logic [15:0] imm);
    logic signed [15:0]     simm;
    logic signed [PC_W-1:0] off;
    simm = imm;
    off  = PC_W'(simm);
    return off <<< 2;
  endfunction

  function automatic bundle_t decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    bundle_t         b;
    logic [PC_W-1:0] pc4;
    b        = '0;
    pc4      = pc + PC_W'(4);
    b.opcode = ins[31:26];
    b.pc     = pc;
    if (ins[31:26] == 6'h00) begin
      b.fmt   = 2'd0;
      b.rs    = ins[25:21];
      b.rt    = ins[20:16];
      b.rd    = ins[15:11];
      b.shamt = ins[10:6];
      b.funct = ins[5:0];
    end else if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) begin
      b.fmt               = 2'd2;
      b.address           = ins[25:0];
      b.jump_target       = pc4;
      b.jump_target[27:0] = {ins[25:0], 2'b00};
    end else begin
      b.fmt           = 2'd1;
      b.rs            = ins[25:21];
      b.rt            = ins[20:16];
      b.immediate     = ins[15:0];
      b.imm_ext       = ext_imm(ins[31:26], ins[15:0]);
      b.branch_target = pc4 + branch_off(ins[15:0]);
    end
    return b;
  endfunction

`ifdef INS_DECODE_ILLEGAL_EN
  function automatic logic is_illegal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: is_illegal = 1'b0;
      default:                                          is_illegal = 1'b1;
    endcase
  endfunction
`endif

  state_t  state, state_nxt;
  bundle_t dec_in, bnd_p0, bnd_skid;
  logic    accept, hs, ld_main_in, ld_main_skid, ld_skid;

  assign dec_in    = decode(instruction, p_count);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt  = ONE;
        ld_main_in = 1'b1;
      end
      ONE: begin
        if (accept && hs) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (hs) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (hs) begin
        state_nxt    = ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0: main output register, control and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      decode_count <= '0;
      bnd_p0       <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (hs) decode_count <= decode_count + CNT_W'(1);
      if (ld_main_in) bnd_p0 <= dec_in;
      else if (ld_main_skid) bnd_p0 <= bnd_skid;
    end
  end

  // Skid entry: contents only meaningful while state is TWO
  always_ff @(posedge clk) begin
    if (ld_skid) bnd_skid <= dec_in;
  end

`ifdef INS_DECODE_ILLEGAL_EN
  logic ill_skid;
  always_ff @(posedge clk) begin
    if (reset) illegal <= 1'b0;
    else if (ld_main_in) illegal <= is_illegal(instruction[31:26]);
    else if (ld_main_skid) illegal <= ill_skid;
    if (ld_skid) ill_skid <= is_illegal(instruction[31:26]);
  end
`endif

  assign opcode        = bnd_p0.opcode;
  assign rs            = bnd_p0.rs;
  assign rt            = bnd_p0.rt;
  assign rd            = bnd_p0.rd;
  assign shamt         = bnd_p0.shamt;
  assign funct         = bnd_p0.funct;
  assign fmt           = bnd_p0.fmt;
  assign immediate     = bnd_p0.immediate;
  assign imm_ext       = bnd_p0.imm_ext;
  assign address       = bnd_p0.address;
  assign pc_out        = bnd_p0.pc;
  assign branch_target = bnd_p0.branch_target;
  assign jump_target   = bnd_p0.jump_target;

endmodule

// File: doc/ins_decode_stage.md
# ins_decode_stage

Registered, handshaked MIPS instruction decode stage that replaces the purely combinational field splitter between fetch and register read. It splits each 32-bit instruction into R/I/J fields and classifies its format. It computes the extended immediate, branch target and jump target. A two-entry skid buffer sustains one instruction per cycle under downstream back-pressure.

## Interface
- PC_W, 32: width of program-counter input and target outputs; legal range 28..32.
- DATA_W, 32: width of extended immediate; must be ≥ 16.
- CNT_W, 16: width of retired-decode counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- instruction  in  32  raw instruction word.
- p_count  in  PC_W  address of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- opcode  out  6  instruction[31:26].
- rs, rt, rd, shamt  out  5 each  register and shift fields.
- funct  out  6  R-type function.
- fmt  out  2  0 = R, 1 = I, 2 = J; 3 is never driven.
- immediate  out  16  raw instruction[15:0].
- imm_ext  out  DATA_W  extended immediate.
- address  out  26  J-type target field.
- pc_out  out  PC_W  p_count carried with the instruction.
- branch_target  out  PC_W  pc + 4 + (sext(imm) << 2).
- jump_target  out  PC_W  {(pc + 4)[PC_W-1:28], address, 2'b00}.
- decode_count  out  CNT_W  number of completed output handshakes.
- illegal  out  1  present only with INS_DECODE_ILLEGAL_EN.

## Operation
- Format classification:
  - opcode 0x00 → R.
  - opcode 0x02 or 0x03 → J.
  - any other opcode → I.
- Field validity per format:
  - R: rs, rt, rd, shamt and funct are valid.
  - I: rs, rt, immediate, imm_ext and branch_target are valid.
  - J: address and jump_target are valid.
- Fields not belonging to the format are driven 0. No field ever holds a stale value from a prior instruction.
- imm_ext rules:
  - opcodes 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI): zero-extended.
  - opcode 0x0F (LUI): {imm, 16'b0}, zero-extended to DATA_W.
  - all other I-type: sign-extended.
- Arithmetic: all PC arithmetic is modulo 2^PC_W, with silent wrap. branch_target always uses the sign-extended immediate, regardless of opcode.
- Storage: a main output register plus one skid register.
  - Accept when in_valid && in_ready.
  - Output handshake when out_valid && out_ready.
  - in_ready is registered and equals "skid empty".
- Buffer states: EMPTY, ONE (main full) and TWO (main and skid full).
  - EMPTY + accept → ONE.
  - ONE + accept without output handshake → TWO; the skid captures the new instruction and in_ready falls.
  - ONE + accept with output handshake → ONE; the new bundle goes to main.
  - ONE + output handshake only → EMPTY.
  - TWO + output handshake → ONE; skid moves to main and in_ready rises.
- In TWO no accept is possible, because in_ready is 0.
- Bundles leave strictly in acceptance order. No bundle is duplicated or dropped.
- decode_count increments on each output handshake and wraps to 0 at 2^CNT_W.

## Timing
- Latency: exactly 1 cycle from the accept edge to out_valid in EMPTY. A bundle behind a stalled one appears in the cycle after the stalled one completes.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Output stability: bundle outputs are stable while out_valid && !out_ready.
- Reset values:
  - out_valid = 0, in_ready = 1.
  - All field, target and pc outputs = 0; fmt = 0.
  - decode_count = 0; illegal = 0.
- Reset dominates. A handshake in a cycle with reset high is discarded, and both buffer entries are flushed. This holds even mid-stall in state TWO.
- out_ready may toggle freely. in_valid must not depend on in_ready combinationally; out_ready may.

## Configuration
- INS_DECODE_ILLEGAL_EN defined:
  - `illegal` is registered with its bundle and asserts when opcode is not in {0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x0F, 0x23, 0x2B}.
  - fmt still follows the normal classification, so an illegal opcode is reported as I.
- Macro undefined: `illegal` port and its logic are absent. All other behaviour is identical.

## Test plan
- 0x00221820, pc 0x00400000, out_ready = 1 → next cycle out_valid = 1, fmt = 0, rs = 1, rt = 2, rd = 3, shamt = 0, funct = 0x20, imm_ext = 0, address = 0.
- 0x1022FFFF (BEQ), pc 0x00400010 → fmt = 1, imm_ext = 0xFFFFFFFF, branch_target = 0x00400010, rd = 0, funct = 0.
- 0x34218000 (ORI) → imm_ext = 0x00008000. 0x3C011234 (LUI) → imm_ext = 0x12340000.
- 0x08100000 (J), pc 0x00400000 → fmt = 2, address = 0x0100000, jump_target = 0x00400000. pc 0xFFFFFFFC with BEQ imm 0 → branch_target = 0x00000000 (wrap).
- out_ready held low while issuing three back-to-back instructions A, B, C:
  - A and B accepted; in_ready falls and C is held upstream.
  - out_ready then held high → output order A, B, C on consecutive cycles; decode_count = 3.
- In state TWO, assert reset for 1 cycle → out_valid = 0, in_ready = 1, decode_count = 0, no stale bundle after release. With the macro defined, opcode 0x3F → illegal = 1; 0x23 → illegal = 0.
